stack_op_sequencer: RTL

- Initiator/master side of the processor's LIFO stack interface. Accepts one stack-machine instruction at a time and drives the stack's push, pop and data_in ports.
- Instructions: PUSH imm, POP, DUP, ADD, SUB, AND, OR. Binary operations pop two operands, compute, and push the result.
- Keeps a shadow element count, rejects under/overflowing instructions with an error pulse, and returns popped or computed values on a result port.

---
 rtl/stack_op_sequencer_pkg.sv | 30 +++
 rtl/stack_op_sequencer_if.sv | 35 +++
 rtl/stack_alu.sv | 25 ++
 rtl/stack_op_sequencer.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/stack_op_sequencer_pkg.sv
// Shared opcodes, sequencer state encoding and decode helpers for the stack-op sequencer.
package stack_op_sequencer_pkg;

    localparam int unsigned OP_W = 3;

    localparam logic [OP_W-1:0] OP_NOP  = 3'b000;
    localparam logic [OP_W-1:0] OP_PUSH = 3'b001;
    localparam logic [OP_W-1:0] OP_POP  = 3'b010;
    localparam logic [OP_W-1:0] OP_DUP  = 3'b011;
    localparam logic [OP_W-1:0] OP_ADD  = 3'b100;
    localparam logic [OP_W-1:0] OP_SUB  = 3'b101;
    localparam logic [OP_W-1:0] OP_AND  = 3'b110;
    localparam logic [OP_W-1:0] OP_OR   = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_POP_A     = 3'd1,
        S_POP_B     = 3'd2,
        S_PUSH_R    = 3'd3,
        S_PUSH_DUP1 = 3'd4,
        S_PUSH_DUP2 = 3'd5,
        S_FIN       = 3'd6
    } state_e;

    // Binary ALU ops all live in the upper half of the opcode space.
    function automatic logic is_alu_op(input logic [OP_W-1:0] op);
        return op[OP_W-1];
    endfunction

endpackage

// File: rtl/stack_op_sequencer_if.sv
// Instruction/result handshake plus LIFO stack port bundle between sequencer and its environment.
interface stack_op_sequencer_if
    import stack_op_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CW    = 4
);
    logic              instr_valid;
    logic              instr_ready;
    logic [OP_W-1:0]   opcode;
    logic [WIDTH-1:0]  imm;
    logic [WIDTH-1:0]  result;
    logic              result_valid;
    logic              done;
    logic              err;
    logic [CW-1:0]     count;
    logic              stk_push;
    logic              stk_pop;
    logic [WIDTH-1:0]  stk_data_in;
    logic [WIDTH-1:0]  stk_data_out;
    logic              stk_full;
    logic              stk_empty;

    modport master (
        input  instr_valid, opcode, imm, stk_data_out, stk_full, stk_empty,
        output instr_ready, result, result_valid, done, err, count,
               stk_push, stk_pop, stk_data_in
    );

    modport slave (
        output instr_valid, opcode, imm, stk_data_out, stk_full, stk_empty,
        input  instr_ready, result, result_valid, done, err, count,
               stk_push, stk_pop, stk_data_in
    );
endinterface

// File: rtl/stack_alu.sv
// Combinational binary ALU for stack-machine ops; computes b op a where a was the top of stack.
module stack_alu
    import stack_op_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [OP_W-1:0]  op,
    output logic [WIDTH-1:0] y
);

    // Arithmetic wraps modulo 2^WIDTH; no carry or borrow is reported.
    always_comb begin
        y = '0;
        case (op)
            OP_ADD:  y = b + a;
            OP_SUB:  y = b - a;
            OP_AND:  y = b & a;
            OP_OR:   y = b | a;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/stack_op_sequencer.sv
// Stack-machine instruction sequencer: drives the LIFO push/pop ports and tracks a shadow element count.
module stack_op_sequencer
    import stack_op_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CW    = $clog2(DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 resetN,
    stack_op_sequencer_if.master bus
);

    state_e           state_q;
    logic [OP_W-1:0]  op_q;
    logic [WIDTH-1:0] a_q;
    logic [CW-1:0]    count_q;
    logic [WIDTH-1:0] result_q;
    logic             result_valid_q;
    logic             done_q;
    logic             err_q;
    logic             push_q;
    logic             pop_q;
    logic [WIDTH-1:0] data_in_q;
    logic             ready_q;

    logic [WIDTH-1:0] alu_y;
    logic             illegal_c;

    // B arrives straight from the stack read port during POP_B, so it needs no holding register.
    stack_alu #(.WIDTH(WIDTH)) u_alu (
        .a  (a_q),
        .b  (bus.stk_data_out),
        .op (op_q),
        .y  (alu_y)
    );

    // Legality uses both the shadow count and the live stack flags.
    always_comb begin
        illegal_c = 1'b0;
        case (bus.opcode)
            OP_NOP:  illegal_c = 1'b0;
            OP_PUSH: illegal_c = (count_q == CW'(DEPTH)) || bus.stk_full;
            OP_POP:  illegal_c = (count_q == '0) || bus.stk_empty;
            OP_DUP:  illegal_c = (count_q == '0) || (count_q == CW'(DEPTH));
            default: illegal_c = (count_q < CW'(2));
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q        <= S_IDLE;
            op_q           <= OP_NOP;
            a_q            <= '0;
            count_q        <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            done_q         <= 1'b0;
            err_q          <= 1'b0;
            push_q         <= 1'b0;
            pop_q          <= 1'b0;
            data_in_q      <= '0;
            ready_q        <= 1'b1;
        end else begin
            result_valid_q <= 1'b0;
            done_q         <= 1'b0;
            err_q          <= 1'b0;
            push_q         <= 1'b0;
            pop_q          <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (bus.instr_valid) begin
                        ready_q <= 1'b0;
                        op_q    <= bus.opcode;
                        if (bus.opcode == OP_NOP) begin
                            done_q  <= 1'b1;
                            state_q <= S_FIN;
                        end else if (illegal_c) begin
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                            state_q <= S_FIN;
                        end else if (bus.opcode == OP_PUSH) begin
                            data_in_q <= bus.imm;
                            push_q    <= 1'b1;
                            state_q   <= S_PUSH_R;
                        end else begin
                            pop_q   <= 1'b1;
                            state_q <= S_POP_A;
                        end
                    end
                end

                S_POP_A: begin
                    a_q     <= bus.stk_data_out;
                    count_q <= count_q - CW'(1);
                    if (op_q == OP_POP) begin
                        result_q       <= bus.stk_data_out;
                        result_valid_q <= 1'b1;
                        done_q         <= 1'b1;
                        state_q        <= S_FIN;
                    end else if (op_q == OP_DUP) begin
                        data_in_q <= bus.stk_data_out;
                        push_q    <= 1'b1;
                        state_q   <= S_PUSH_DUP1;
                    end else begin
                        pop_q   <= 1'b1;
                        state_q <= S_POP_B;
                    end
                end

                S_POP_B: begin
                    count_q   <= count_q - CW'(1);
                    data_in_q <= alu_y;
                    push_q    <= 1'b1;
                    state_q   <= S_PUSH_R;
                end

                S_PUSH_R: begin
                    count_q <= count_q + CW'(1);
                    done_q  <= 1'b1;
                    if (is_alu_op(op_q)) begin
                        result_q       <= data_in_q;
                        result_valid_q <= 1'b1;
                    end
                    state_q <= S_FIN;
                end

                S_PUSH_DUP1: begin
                    count_q <= count_q + CW'(1);
                    push_q  <= 1'b1;
                    state_q <= S_PUSH_DUP2;
                end

                S_PUSH_DUP2: begin
                    count_q        <= count_q + CW'(1);
                    result_q       <= a_q;
                    result_valid_q <= 1'b1;
                    done_q         <= 1'b1;
                    state_q        <= S_FIN;
                end

                S_FIN: begin
                    ready_q <= 1'b1;
                    state_q <= S_IDLE;
                end

                default: begin
                    ready_q <= 1'b1;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.instr_ready  = ready_q;
    assign bus.result       = result_q;
    assign bus.result_valid = result_valid_q;
    assign bus.done         = done_q;
    assign bus.err          = err_q;
    assign bus.count        = count_q;
    assign bus.stk_push     = push_q;
    assign bus.stk_pop      = pop_q;
    assign bus.stk_data_in  = data_in_q;

endmodule
